// File: rtl/bcd2421_counter_ctrl.sv
// Multi-digit decade up/down counter controller with a time-shared 2421 encoder and digit scanner.
// Optional parallel load is compiled in when BCD2421_LOAD_EN is defined.
module bcd2421_counter_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              dir,
`ifdef BCD2421_LOAD_EN
  input  logic              load,
  input  logic [4*DIGITS-1:0] load_val,
`endif
  output logic [DIGITS-1:0] digit_sel,
  output logic [3:0]        code2421,
  output logic              running,
  output logic              tc,
  output logic              overflow
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [3:0]      dig     [DIGITS];
  logic [3:0]      dig_cnt [DIGITS];
  logic [3:0]      dig_ld  [DIGITS];
  logic [PW-1:0]   pre, pre_nxt;
  logic [SW-1:0]   sdiv;
  logic [IW-1:0]   sidx;
  logic            do_load, tick, wrap;
  logic            running_nxt, tc_nxt, overflow_nxt;

  function automatic logic [3:0] enc2421(input logic [3:0] d);
    case (d)
      4'd0: enc2421 = 4'b0000;
      4'd1: enc2421 = 4'b0001;
      4'd2: enc2421 = 4'b0010;
      4'd3: enc2421 = 4'b0011;
      4'd4: enc2421 = 4'b0100;
      4'd5: enc2421 = 4'b1011;
      4'd6: enc2421 = 4'b1100;
      4'd7: enc2421 = 4'b1101;
      4'd8: enc2421 = 4'b1110;
      4'd9: enc2421 = 4'b1111;
      default: enc2421 = 4'b0000;
    endcase
  endfunction

`ifdef BCD2421_LOAD_EN
  always_comb begin
    do_load = load;
    for (int i = 0; i < DIGITS; i++) begin
      dig_ld[i] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end
`else
  always_comb begin
    do_load = 1'b0;
    for (int i = 0; i < DIGITS; i++) dig_ld[i] = 4'd0;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: clear > load > stop > start
  always_comb begin
    state_nxt = state;
    if (clear)            state_nxt = IDLE;
    else if (do_load)     state_nxt = state;
    else if (stop) begin
      if (state == RUN)   state_nxt = HOLD;
    end else if (start && state != RUN) begin
      state_nxt = RUN;
    end
  end

  assign tick = (state == RUN) && (pre == PW'(PRESCALE - 1)) && !clear && !do_load && !stop;

  // Carry/borrow ripple; wrap is the carry out of the top digit.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig_cnt[i] = dig[i];
      if (carry) begin
        if (dir) begin
          if (dig[i] >= 4'd9) dig_cnt[i] = 4'd0;
          else begin dig_cnt[i] = dig[i] + 4'd1; carry = 1'b0; end
        end else begin
          if (dig[i] == 4'd0) dig_cnt[i] = 4'd9;
          else begin dig_cnt[i] = dig[i] - 4'd1; carry = 1'b0; end
        end
      end
    end
    wrap = carry;
  end

  always_comb begin
    pre_nxt = pre;
    if (clear || do_load)                pre_nxt = '0;
    else if (state == IDLE)              pre_nxt = '0;
    else if (state == RUN && !stop)      pre_nxt = tick ? '0 : pre + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre <= '0;
      for (int i = 0; i < DIGITS; i++) dig[i] <= 4'd0;
    end else begin
      pre <= pre_nxt;
      for (int i = 0; i < DIGITS; i++) begin
        if (clear)        dig[i] <= 4'd0;
        else if (do_load) dig[i] <= dig_ld[i];
        else if (tick)    dig[i] <= dig_cnt[i];
      end
    end
  end

  // Output comb: next values for the registered status outputs
  always_comb begin
    running_nxt  = (state_nxt == RUN);
    tc_nxt       = tick && wrap;
    overflow_nxt = overflow;
    if (clear)            overflow_nxt = 1'b0;
    else if (tick && wrap) overflow_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      running  <= 1'b0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      running  <= running_nxt;
      tc       <= tc_nxt;
      overflow <= overflow_nxt;
    end
  end

  // Scanner: select and code are captured together from the same index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sdiv      <= '0;
      sidx      <= '0;
      digit_sel <= DIGITS'(1);
      code2421  <= 4'b0000;
    end else begin
      if (sdiv == SW'(SCAN_DIV - 1)) begin
        sdiv <= '0;
        sidx <= (sidx == IW'(DIGITS - 1)) ? '0 : sidx + IW'(1);
      end else begin
        sdiv <= sdiv + SW'(1);
      end
      digit_sel <= DIGITS'(1) << sidx;
      code2421  <= enc2421(dig[sidx]);
    end
  end

endmodule
